// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline hold-vector generator with a multi-cycle sequencer.
//
// Combines per-stage hold requests and an IDLE/BUSY/DONE multi-cycle
// sequencer into a contiguous-from-bit0 stall vector.
//
// Optional feature macro: PIPE_STALL_CNT_EN
//   defined   : stall_cycles counts edges with stall[0]=1, saturating.
//   undefined : stall_cycles is tied to 32'h0 (no counter logic).
//
// Ports
//   clk           in   pipeline clock, all state updates on rising edge
//   rst           in   synchronous active-high reset
//   stallreq_if   in   fetch stage hold request
//   stallreq_id   in   decode stage hold request (load-use)
//   stallreq_ex   in   execute stage single-cycle hold request
//   stallreq_mem  in   memory stage hold request
//   mc_req        in   multi-cycle operation request (held until mc_done)
//   mc_len  [5:0] in   multi-cycle length in cycles, sampled with mc_req
//   mc_cancel     in   abort an in-flight multi-cycle operation
//   stall   [5:0] out  hold vector: pc, if/id, id/ex, ex/mem, mem/wb, wb
//   mc_busy       out  sequencer is in BUSY
//   mc_done       out  one-cycle pulse, multi-cycle result valid
//   stall_cycles  out  number of cycles with stall[0]=1
// -----------------------------------------------------------------------------
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        mc_req,
  input  logic [5:0]  mc_len,
  input  logic        mc_cancel,
  output logic [5:0]  stall,
  output logic        mc_busy,
  output logic        mc_done,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [5:0] cnt_reg, cnt_next;
  logic       seq_hold;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (mc_req && !mc_cancel) begin
          state_next = BUSY;
          // A zero length runs as a one-cycle operation.
          cnt_next   = (mc_len == 6'd0) ? 6'd0 : mc_len - 6'd1;
        end
      end
      BUSY: begin
        if (mc_cancel) begin
          state_next = IDLE;
        end else if (cnt_reg == 6'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 6'd1;
        end
      end
      DONE: begin
        // mc_req is still high here by protocol; it is deliberately ignored.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 6'd0;
      end
    endcase
  end

  assign mc_busy = (state_reg == BUSY);
  assign mc_done = (state_reg == DONE);

  // The request cycle itself already holds the pipe, so an operation
  // costs 1 + length stall cycles in total.
  assign seq_hold = (state_reg == BUSY) || ((state_reg == IDLE) && mc_req);

  // Priority-encoded hold vector; always contiguous ones from bit0.
  always_comb begin
    stall = 6'b000000;
    if (rst) begin
      stall = 6'b000000;
    end else if (stallreq_mem) begin
      stall = 6'b011111;
    end else if (stallreq_ex || seq_hold) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end else if (stallreq_if) begin
      stall = 6'b000011;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= 32'd0;
    end else if (stall[0] && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule
